beat_detect_multiband: RTL and testbench



---
 rtl/beat_pkg.sv | 18 +
 rtl/beat_band_tracker.sv | 127 ++++++++++++
 rtl/beat_detect_multiband.sv | 83 ++++++++
 tb/tb_beat_detect_multiband.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beat_pkg.sv
// Shared types and width helpers for the multi-band beat detector.
package beat_pkg;

  typedef enum logic [1:0] {
    WARMUP,
    ARMED,
    HOLDOFF
  } band_state_t;

  function automatic int hist_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int acc_w(input int mag_w, input int idx_w);
    return mag_w + idx_w;
  endfunction

endpackage

// File: rtl/beat_band_tracker.sv
// One band: frame accumulator, energy history ring with running sum, and the
// warmup/armed/hold-off decision FSM. Decision lands two cycles after frame end.
module beat_band_tracker
  import beat_pkg::*;
#(
  parameter int MAG_W      = 24,
  parameter int ACC_W      = 31,
  parameter int HIST_DEPTH = 8,
  parameter int HOLDOFF_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 add_en,
  input  logic [MAG_W-1:0]     mag,
  input  logic                 frame_sync,
  input  logic                 frame_end,
  input  logic [3:0]           sens_shift,
  input  logic [ACC_W-1:0]     min_energy,
  input  logic [HOLDOFF_W-1:0] holdoff_frames,
  output logic                 beat,
  output logic [ACC_W-1:0]     energy
);

  localparam int AW     = hist_aw(HIST_DEPTH);
  localparam int HS_W   = ACC_W + AW;
  localparam int FILL_W = AW + 1;

  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [ACC_W-1:0]     e_s1_q, e_s1_d;
  logic                 s1_vld_q, s1_vld_d;
  logic [ACC_W-1:0]     hist_q [HIST_DEPTH];
  logic [ACC_W-1:0]     hist_d [HIST_DEPTH];
  logic [AW-1:0]        wptr_q, wptr_d;
  logic [HS_W-1:0]      hist_sum_q, hist_sum_d;
  band_state_t          state_q, state_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [HOLDOFF_W-1:0] hold_q, hold_d;
  logic                 beat_q, beat_d;
  logic [ACC_W-1:0]     energy_q, energy_d;

  logic [ACC_W-1:0] addend, acc_sum, avg;
  logic [ACC_W:0]   thr;
  logic             meets;

  always_comb begin
    addend  = add_en ? ACC_W'(mag) : '0;
    // A frame sync drops the partial frame before this bin is added.
    acc_sum = (frame_sync ? '0 : acc_q) + addend;
    acc_d   = acc_sum;
    e_s1_d  = e_s1_q;
    s1_vld_d = 1'b0;
    if (frame_end) begin
      e_s1_d   = acc_sum;
      s1_vld_d = 1'b1;
      acc_d    = '0;
    end

    avg   = ACC_W'(hist_sum_q >> AW);
    thr   = {1'b0, avg} + ({1'b0, avg} >> sens_shift);
    meets = ({1'b0, e_s1_q} > thr) && (e_s1_q >= min_energy);

    hist_d     = hist_q;
    wptr_d     = wptr_q;
    hist_sum_d = hist_sum_q;
    state_d    = state_q;
    fill_d     = fill_q;
    hold_d     = hold_q;
    beat_d     = 1'b0;
    energy_d   = energy_q;
    if (s1_vld_q) begin
      energy_d       = e_s1_q;
      hist_d[wptr_q] = e_s1_q;
      wptr_d         = wptr_q + 1'b1;
      hist_sum_d     = hist_sum_q + HS_W'(e_s1_q) - HS_W'(hist_q[wptr_q]);
      case (state_q)
        WARMUP: begin
          fill_d = fill_q + 1'b1;
          if (fill_d == FILL_W'(HIST_DEPTH)) state_d = ARMED;
        end
        ARMED: begin
          if (meets) begin
            beat_d = 1'b1;
            hold_d = holdoff_frames;
            if (holdoff_frames != '0) state_d = HOLDOFF;
          end
        end
        HOLDOFF: begin
          hold_d = hold_q - 1'b1;
          if (hold_d == '0) state_d = ARMED;
        end
        default: state_d = WARMUP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q      <= '0;
      e_s1_q     <= '0;
      s1_vld_q   <= 1'b0;
      hist_q     <= '{default: '0};
      wptr_q     <= '0;
      hist_sum_q <= '0;
      state_q    <= WARMUP;
      fill_q     <= '0;
      hold_q     <= '0;
      beat_q     <= 1'b0;
      energy_q   <= '0;
    end else begin
      acc_q      <= acc_d;
      e_s1_q     <= e_s1_d;
      s1_vld_q   <= s1_vld_d;
      hist_q     <= hist_d;
      wptr_q     <= wptr_d;
      hist_sum_q <= hist_sum_d;
      state_q    <= state_d;
      fill_q     <= fill_d;
      hold_q     <= hold_d;
      beat_q     <= beat_d;
      energy_q   <= energy_d;
    end
  end

  assign beat   = beat_q;
  assign energy = energy_q;

endmodule

// File: rtl/beat_detect_multiband.sv
// Multi-band beat detector: decodes bin membership and frame strobes, fans out
// to one tracker per band, and merges their flags and energies.
module beat_detect_multiband
  import beat_pkg::*;
#(
  parameter int                         NUM_BANDS  = 4,
  parameter int                         MAG_W      = 24,
  parameter int                         IDX_W      = 7,
  parameter int                         LAST_INDEX = 127,
  parameter logic [NUM_BANDS*IDX_W-1:0] BAND_LO    = {7'd1, 7'd4, 7'd12, 7'd32},
  parameter logic [NUM_BANDS*IDX_W-1:0] BAND_HI    = {7'd3, 7'd11, 7'd31, 7'd63},
  parameter int                         HIST_DEPTH = 8,
  parameter int                         HOLDOFF_W  = 8,
  parameter int                         ACC_W      = acc_w(MAG_W, IDX_W)
) (
  input  logic                       clk_100mhz,
  input  logic                       rst_n,
  input  logic                       valid_in,
  input  logic [MAG_W-1:0]           fft_mag,
  input  logic [IDX_W-1:0]           fft_index,
  input  logic [3:0]                 sens_shift,
  input  logic [ACC_W-1:0]           min_energy,
  input  logic [HOLDOFF_W-1:0]       holdoff_frames,
  output logic [NUM_BANDS-1:0]       beat_flags,
  output logic                       beat_any,
  output logic [NUM_BANDS*ACC_W-1:0] band_energy,
  output logic                       energy_valid
);

  logic                 frame_sync, frame_end;
  logic [NUM_BANDS-1:0] add_en;
  logic                 fe_s1_q, fe_s1_d;
  logic                 ev_q, ev_d;

  assign frame_sync = valid_in && (fft_index == '0);
  assign frame_end  = valid_in && (fft_index == IDX_W'(LAST_INDEX));

  for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
    localparam logic [IDX_W-1:0] LO = BAND_LO[b*IDX_W +: IDX_W];
    localparam logic [IDX_W-1:0] HI = BAND_HI[b*IDX_W +: IDX_W];

    assign add_en[b] = valid_in && (fft_index >= LO) && (fft_index <= HI);

    beat_band_tracker #(
      .MAG_W      (MAG_W),
      .ACC_W      (ACC_W),
      .HIST_DEPTH (HIST_DEPTH),
      .HOLDOFF_W  (HOLDOFF_W)
    ) u_tracker (
      .clk            (clk_100mhz),
      .rst_n          (rst_n),
      .add_en         (add_en[b]),
      .mag            (fft_mag),
      .frame_sync     (frame_sync),
      .frame_end      (frame_end),
      .sens_shift     (sens_shift),
      .min_energy     (min_energy),
      .holdoff_frames (holdoff_frames),
      .beat           (beat_flags[b]),
      .energy         (band_energy[b*ACC_W +: ACC_W])
    );
  end

  // Mirrors the tracker pipeline so energy_valid aligns with the band outputs.
  always_comb begin
    fe_s1_d = frame_end;
    ev_d    = fe_s1_q;
  end

  always_ff @(posedge clk_100mhz) begin
    if (!rst_n) begin
      fe_s1_q <= 1'b0;
      ev_q    <= 1'b0;
    end else begin
      fe_s1_q <= fe_s1_d;
      ev_q    <= ev_d;
    end
  end

  assign energy_valid = ev_q;
  assign beat_any     = |beat_flags;

endmodule

// File: tb/tb_beat_detect_multiband.sv
// Randomized and directed checks of beat_detect_multiband against a frame-level model.
`timescale 1ns/1ps
module tb_beat_detect_multiband;

  localparam int NB    = 2;
  localparam int MAG_W = 24;
  localparam int IDX_W = 7;
  localparam int LAST  = 127;
  localparam int HD    = 4;
  localparam int HO_W  = 8;
  localparam int ACC_W = MAG_W + IDX_W;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  valid_in = 1'b0;
  logic [MAG_W-1:0]      fft_mag = '0;
  logic [IDX_W-1:0]      fft_index = '0;
  logic [3:0]            sens_shift = 4'd2;
  logic [ACC_W-1:0]      min_energy = 50;
  logic [HO_W-1:0]       holdoff_frames = '0;
  logic [NB-1:0]         beat_flags;
  logic                  beat_any;
  logic [NB*ACC_W-1:0]   band_energy;
  logic                  energy_valid;

  beat_detect_multiband #(
    .NUM_BANDS  (NB),
    .MAG_W      (MAG_W),
    .IDX_W      (IDX_W),
    .LAST_INDEX (LAST),
    .BAND_LO    ({7'd4, 7'd1}),
    .BAND_HI    ({7'd7, 7'd3}),
    .HIST_DEPTH (HD),
    .HOLDOFF_W  (HO_W)
  ) dut (
    .clk_100mhz     (clk),
    .rst_n          (rst_n),
    .valid_in       (valid_in),
    .fft_mag        (fft_mag),
    .fft_index      (fft_index),
    .sens_shift     (sens_shift),
    .min_energy     (min_energy),
    .holdoff_frames (holdoff_frames),
    .beat_flags     (beat_flags),
    .beat_any       (beat_any),
    .band_energy    (band_energy),
    .energy_valid   (energy_valid)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int ev_count = 0;
  int beat_cycles = 0;
  logic [1:0] lat_flags = '0;
  longint lat_e0 = 0;
  longint lat_e1 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Frame-level reference: band sums, energy history, hold-off countdown.
  typedef struct {
    int         due;
    logic [1:0] flags;
    longint     e0;
    longint     e1;
  } exp_t;

  exp_t   expq[$];
  longint acc_m[NB];
  longint hist_m[NB][$];
  int     hold_m[NB];
  int     lo_m[NB] = '{1, 4};
  int     hi_m[NB] = '{3, 7};

  task automatic model_clear();
    for (int b = 0; b < NB; b++) begin
      acc_m[b] = 0;
      hist_m[b].delete();
      hold_m[b] = 0;
    end
    expq.delete();
  endtask

  task automatic model_step(input bit v, input int idx, input int mag);
    exp_t   x;
    longint e, sum, avg, thr;
    if (!v) return;
    if (idx == 0) for (int b = 0; b < NB; b++) acc_m[b] = 0;
    for (int b = 0; b < NB; b++)
      if (idx >= lo_m[b] && idx <= hi_m[b]) acc_m[b] += mag;
    if (idx == LAST) begin
      x.due = cyc + 2;
      x.flags = '0;
      for (int b = 0; b < NB; b++) begin
        e = acc_m[b];
        if (hist_m[b].size() == HD) begin
          sum = 0;
          foreach (hist_m[b][i]) sum += hist_m[b][i];
          avg = sum / HD;
          thr = avg + (avg >> int'(sens_shift));
          if (hold_m[b] > 0) hold_m[b]--;
          else if (e > thr && e >= longint'(min_energy)) begin
            x.flags[b] = 1'b1;
            hold_m[b] = int'(holdoff_frames);
          end
        end
        hist_m[b].push_back(e);
        if (hist_m[b].size() > HD) void'(hist_m[b].pop_front());
        acc_m[b] = 0;
      end
      x.e0 = acc_m[0];
      x.e0 = hist_m[0][hist_m[0].size()-1];
      x.e1 = hist_m[1][hist_m[1].size()-1];
      expq.push_back(x);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (beat_any === 1'b1) beat_cycles++;
      while (expq.size() > 0 && expq[0].due < cyc) begin
        chk("late_result", 64'(cyc), 64'(expq[0].due));
        void'(expq.pop_front());
      end
      if (expq.size() > 0 && expq[0].due == cyc) begin
        chk("ev", 64'(energy_valid), 64'd1);
        chk("flags", 64'(beat_flags), 64'(expq[0].flags));
        chk("any", 64'(beat_any), 64'(|expq[0].flags));
        chk("e0", 64'(band_energy[ACC_W-1:0]), 64'(expq[0].e0));
        chk("e1", 64'(band_energy[2*ACC_W-1:ACC_W]), 64'(expq[0].e1));
        ev_count++;
        lat_flags = beat_flags;
        lat_e0 = longint'(band_energy[ACC_W-1:0]);
        lat_e1 = longint'(band_energy[2*ACC_W-1:ACC_W]);
        void'(expq.pop_front());
      end else begin
        chk("idle_out", 64'({energy_valid, beat_any, beat_flags}), 64'd0);
      end
    end
  end

  task automatic drive(input bit v, input int idx, input int mag);
    @(posedge clk);
    #1;
    valid_in  = v;
    fft_index = IDX_W'(idx);
    fft_mag   = MAG_W'(mag);
    model_step(v, idx, mag);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, int'($urandom_range(0, 127)), int'($urandom_range(0, 5000)));
  endtask

  task automatic frame(input int m_low, input int m_other);
    for (int i = 0; i <= LAST; i++)
      drive(1'b1, i, (i >= 1 && i <= 3) ? m_low : m_other);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    valid_in = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", 64'({beat_any, beat_flags}), 64'd0);
    chk("rst_energy", 64'(band_energy), 64'd0);
    chk("rst_ev", 64'(energy_valid), 64'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int evc0, bc0, scale;
    holdoff_frames = 8'd2;
    do_reset();
    mon_en = 1'b1;
    idle(2);

    // Partial frame cut off by reset yields nothing.
    for (int i = 0; i < 127; i++) drive(1'b1, i, 100);
    do_reset();
    idle(4);
    chk("s1_no_ev", 64'(ev_count), 64'd0);

    // Warmup frames.
    repeat (4) frame(100, 100);
    idle(3);
    chk("s2_e0", 64'(lat_e0), 64'd300);
    chk("s2_e1", 64'(lat_e1), 64'd400);
    chk("s2_evcnt", 64'(ev_count), 64'd4);
    chk("s2_nobeat", 64'(beat_cycles), 64'd0);

    frame(400, 100);
    idle(3);
    chk("s3_flags", 64'(lat_flags), 64'd1);
    chk("s3_e0", 64'(lat_e0), 64'd1200);
    chk("s3_beat_cycles", 64'(beat_cycles), 64'd1);

    repeat (2) frame(400, 100);
    idle(3);
    chk("s4_holdoff", 64'(beat_cycles), 64'd1);
    frame(2000, 100);
    idle(3);
    chk("s4_flags", 64'(lat_flags), 64'd1);
    chk("s4_e0", 64'(lat_e0), 64'd6000);
    chk("s4_beat_cycles", 64'(beat_cycles), 64'd2);

    // Energy floor.
    do_reset();
    repeat (4) frame(0, 0);
    frame(10, 0);
    idle(3);
    chk("s5_floor_e0", 64'(lat_e0), 64'd30);
    chk("s5_floor_flags", 64'(lat_flags), 64'd0);
    min_energy = 20;
    frame(10, 0);
    idle(3);
    chk("s5_beat_flags", 64'(lat_flags), 64'd1);

    // Mid-frame resync, then back-to-back frame ends.
    drive(1'b1, 0, 0);
    drive(1'b1, 1, 999);
    drive(1'b1, 2, 999);
    frame(100, 100);
    idle(3);
    chk("s6_resync_e0", 64'(lat_e0), 64'd300);
    evc0 = ev_count;
    drive(1'b1, 127, 5);
    drive(1'b1, 0, 5);
    drive(1'b1, 127, 5);
    idle(4);
    chk("s6_b2b", 64'(ev_count - evc0), 64'd2);

    // Randomized frames and configuration.
    do_reset();
    bc0 = 0;
    for (int f = 0; f < 40; f++) begin
      sens_shift     = 4'($urandom_range(0, 3));
      min_energy     = ACC_W'($urandom_range(0, 2000));
      holdoff_frames = HO_W'($urandom_range(0, 2));
      case ($urandom_range(0, 2))
        0: scale = 50;
        1: scale = 500;
        default: scale = 3000;
      endcase
      for (int i = 0; i <= LAST; i++) begin
        if ($urandom_range(0, 15) == 0) idle(1);
        drive(1'b1, i, int'($urandom_range(0, scale)));
      end
      idle(3);
      if (lat_flags != 0) bc0++;
    end
    idle(4);
    chk("rand_queue_drained", 64'(expq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
